regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write-enable, write address, write data) between two writers:
  - the in-order pipeline writeback stage;
  - the long-latency multiply/divide unit (MDU).
- Keeps a 32-entry pending scoreboard for MDU destinations and flags read-after-write and write-after-write hazards to the decode stage.
- Sits between the writeback stage, the MDU, and the register file; the decode stage reads its hazard outputs.

Parameters:
- XLEN, 32, data width of the write port.
- STARVE_MAX, 4, number of consecutive denied MDU cycles before a forced grant (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_we  in  1  pipeline writeback request.
- wb_rd  in  5  pipeline destination register.
- wb_data  in  XLEN  pipeline write data.
- wb_stall  out  1  pipeline must hold its writeback this cycle.
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  XLEN  MDU result.
- mdu_ready  out  1  MDU result accepted this cycle.
- iss_valid  in  1  decode issues an MDU operation.
- iss_rd  in  5  destination of the issued MDU operation.
- iss_ready  out  1  issue accepted.
- chk_rs1, chk_rs2, chk_rd  in  5 each  decode operand and destination addresses to check.
- hz_rs1, hz_rs2, hz_rd  out  1 each  hazard on the matching address.
- rf_we  out  1  register-file write enable.
- rf_addr  out  5  register-file write address.
- rf_data  out  XLEN  register-file write data.
- pend_cnt  out  6  number of pending bits set (0..31).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: pending[31:0]=0, starve counter=0.
- Outputs while rst is high: rf_we=0, mdu_ready=0, iss_ready=0, wb_stall=0, hz_*=0, pend_cnt=0.
- Write-port grant (combinational, zero latency), in strict priority order:
  - Forced grant (feature only): wb_stall=1, MDU drives the write port.
  - Else if wb_we=1: pipeline drives the port, mdu_ready=0.
  - Else if mdu_valid=1: MDU drives the port, mdu_ready=1.
  - Else: rf_we=0, rf_addr=0, rf_data=0.
- x0 writes: rf_we is forced to 0 whenever the granted address is 0. The MDU handshake still completes on an x0 result.
- MDU handshake: a transfer occurs on a rising edge with mdu_valid&mdu_ready. The MDU holds rd and data stable until that edge.
- Scoreboard set:
  - iss_ready = !pending[iss_rd].
  - iss_valid&iss_ready with iss_rd!=0 sets pending[iss_rd] at the edge.
  - Issuing to x0 is accepted and sets nothing.
- Scoreboard clear: a completed MDU transfer clears pending[mdu_rd].
- Simultaneous set and clear of the same register: set wins; the bit stays 1.
- Clearing a bit that is not pending has no effect and is not an error.
- Hazard outputs (combinational):
  - hz_x = pending[chk_x] & (chk_x!=0), for x in rs1, rs2, rd.
  - A bit being cleared this cycle still reports a hazard; it is released on the following cycle. There is no forwarding.
- pend_cnt: registered popcount of pending. It updates on the same edge as the pending bits.
- Reset mid-operation: all pending bits are dropped. In-flight MDU results arriving after reset are written to the register file and leave no residual pending bits.

Optional Feature:
- Macro: REGFILE_ARB_FAIRNESS_EN.
- With the macro defined:
  - The starve counter (width clog2(STARVE_MAX+1)) increments on each cycle with mdu_valid&!mdu_ready.
  - The counter clears on any MDU transfer.
  - When counter==STARVE_MAX and mdu_valid=1: wb_stall=1, the MDU is granted, and the counter clears at that edge.
  - The pipeline holds wb_we, wb_rd and wb_data across any stalled cycle.
- Without the macro: no counter exists, wb_stall is tied 0, and strict pipeline priority applies, so the MDU may starve indefinitely.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and REG_ADDR_W=5;
  - NUM_REGS=32;
  - typedef reg_addr_t (logic[4:0]);
  - typedef xlen_t (logic[XLEN-1:0]).
- Sub-module rf_scoreboard holds the pending vector, iss_ready, the hazard lookups and pend_cnt.
- The top level holds the write-port mux and the starve counter.

Test Plan:
- Reset, then iss_valid, iss_rd=5 → next cycle hz_rs1=1 with chk_rs1=5, pend_cnt=1; iss_ready=0 for a second issue to rd=5.
- wb_we=1 (rd=3, data 0xAAAA_0001) and mdu_valid=1 (rd=5, 0x1234) in the same cycle → rf_addr=3, mdu_ready=0. Next cycle, with wb_we=0 → rf_addr=5, rf_we=1, pending[5] clears, pend_cnt=0.
- MDU transfer to rd=7 and new issue to rd=7 on the same edge → pending[7] stays 1, hz_rd=1 with chk_rd=7.
- iss_rd=0 and an MDU result to rd=0 → no pending bit set, rf_we=0, mdu_ready=1, hz_* stay 0.
- With REGFILE_ARB_FAIRNESS_EN, wb_we held 1 and mdu_valid held 1 → wb_stall=1 on cycle 5 (after 4 denials), MDU granted that cycle, counter returns to 0. Without the macro → wb_stall never asserts.
- Set pending for rd 1, 2 and 3, then assert rst mid-cycle → all hz_*=0 and pend_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : rv_pkg
// Brief   : Shared register-file widths, address/data types and a popcount
//           helper used by the write-port arbiter and its scoreboard.
// Rev     : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // Number of set bits in a NUM_REGS-wide vector; bit 0 is never set by the
  // scoreboard, so the result always fits in 6 bits (0..31).
  function automatic logic [5:0] popcount_regs(input logic [NUM_REGS-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage : rv_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : rf_scoreboard
// Brief   : Pending-destination scoreboard for long-latency MDU results.
//           Sets a bit on an accepted issue, clears it on a completed MDU
//           transfer (set wins on a collision) and reports hazards.
// Rev     : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import rv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_iss_valid,
  input  reg_addr_t i_iss_rd,
  output logic      o_iss_ready,
  input  logic      i_clr_valid,
  input  reg_addr_t i_clr_rd,
  input  reg_addr_t i_chk_rs1,
  input  reg_addr_t i_chk_rs2,
  input  reg_addr_t i_chk_rd,
  output logic      o_hz_rs1,
  output logic      o_hz_rs2,
  output logic      o_hz_rd,
  output logic [5:0] o_pend_cnt
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic [5:0]          r_pend_cnt;
  logic                w_set;

  // An issue is refused while its destination is still outstanding.
  assign o_iss_ready = !rst && !r_pending[i_iss_rd];
  assign w_set       = i_iss_valid && o_iss_ready && (i_iss_rd != '0);

  // Clear first, then set, so a same-register collision leaves the bit set.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_valid) begin
      w_pending_nxt[i_clr_rd] = 1'b0;
    end
    if (w_set) begin
      w_pending_nxt[i_iss_rd] = 1'b1;
    end
  end

  // Pending vector and its population count advance on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_pend_cnt <= popcount_regs(w_pending_nxt);
    end
  end

  // Hazards read the current (pre-clear) state: no forwarding of results.
  assign o_hz_rs1   = r_pending[i_chk_rs1] && (i_chk_rs1 != '0);
  assign o_hz_rs2   = r_pending[i_chk_rs2] && (i_chk_rs2 != '0);
  assign o_hz_rd    = r_pending[i_chk_rd]  && (i_chk_rd  != '0);
  assign o_pend_cnt = r_pend_cnt;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Arbitrates the single register-file write port between the
//           pipeline writeback stage and the multiply/divide unit, and hosts
//           the MDU pending scoreboard for decode hazard checks.
//           Optional MDU anti-starvation: define REGFILE_ARB_FAIRNESS_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  reg_addr_t       wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_stall,
  input  logic            mdu_valid,
  input  reg_addr_t       mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  input  logic            iss_valid,
  input  reg_addr_t       iss_rd,
  output logic            iss_ready,
  input  reg_addr_t       chk_rs1,
  input  reg_addr_t       chk_rs2,
  input  reg_addr_t       chk_rd,
  output logic            hz_rs1,
  output logic            hz_rs2,
  output logic            hz_rd,
  output logic            rf_we,
  output reg_addr_t       rf_addr,
  output logic [XLEN-1:0] rf_data,
  output logic [5:0]      pend_cnt
);

  logic            w_forced;
  logic            w_gnt_wb;
  logic            w_gnt_mdu;
  logic            w_xfer;
  reg_addr_t       w_addr;
  logic [XLEN-1:0] w_data;

`ifdef REGFILE_ARB_FAIRNESS_EN
  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] r_starve;

  assign w_forced = mdu_valid && (r_starve == STARVE_W'(STARVE_MAX));

  // Count consecutive denied MDU cycles; any completed transfer restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_xfer) begin
      r_starve <= '0;
    end else if (mdu_valid) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_forced = 1'b0;
`endif

  // Strict priority: forced MDU grant, then pipeline, then MDU.
  always_comb begin
    w_gnt_wb  = 1'b0;
    w_gnt_mdu = 1'b0;
    if (w_forced) begin
      w_gnt_mdu = 1'b1;
    end else if (wb_we) begin
      w_gnt_wb = 1'b1;
    end else if (mdu_valid) begin
      w_gnt_mdu = 1'b1;
    end
  end

  // Write-port mux; an idle port presents zero address and data.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    if (w_gnt_wb) begin
      w_addr = wb_rd;
      w_data = wb_data;
    end else if (w_gnt_mdu) begin
      w_addr = mdu_rd;
      w_data = mdu_data;
    end
  end

  // x0 is never written, but the MDU handshake still completes on it.
  assign rf_we     = !rst && (w_gnt_wb || w_gnt_mdu) && (w_addr != '0);
  assign rf_addr   = w_addr;
  assign rf_data   = w_data;
  assign mdu_ready = !rst && w_gnt_mdu;
  assign wb_stall  = !rst && w_forced;
  assign w_xfer    = mdu_valid && mdu_ready;

  rf_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_clr_valid (w_xfer),
    .i_clr_rd    (mdu_rd),
    .i_chk_rs1   (chk_rs1),
    .i_chk_rs2   (chk_rs2),
    .i_chk_rd    (chk_rd),
    .o_hz_rs1    (hz_rs1),
    .o_hz_rs2    (hz_rs2),
    .o_hz_rd     (hz_rd),
    .o_pend_cnt  (pend_cnt)
  );

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Self-checking bench for regfile_wb_arbiter: directed scenarios
//           followed by randomized traffic against a behavioural model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_we, mdu_valid, iss_valid;
  logic [4:0]      wb_rd, mdu_rd, iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic [XLEN-1:0] wb_data, mdu_data;
  logic            wb_stall, mdu_ready, iss_ready, hz_rs1, hz_rs2, hz_rd, rf_we;
  logic [4:0]      rf_addr;
  logic [XLEN-1:0] rf_data;
  logic [5:0]      pend_cnt;

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: set of outstanding MDU destinations plus a denial count.
  bit mp[32];
  int starve;
  int stall_seen;
  bit held_mdu, held_wb;

  task automatic model_reset();
    foreach (mp[i]) mp[i] = 1'b0;
    starve   = 0;
    held_mdu = 1'b0;
    held_wb  = 1'b0;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    iss_valid = 0; iss_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  // Called at a falling edge with inputs already applied: check every output
  // against the model, cross the rising edge, update the model.
  task automatic tick();
    int cnt;
    bit forced, g_wb, g_mdu, exp_we, ir;
    logic [4:0] ea;
    logic [XLEN-1:0] ed;
    cnt = 0;
    foreach (mp[i]) cnt += mp[i];
    chk("pend_cnt", pend_cnt, cnt);
    #1;
`ifdef REGFILE_ARB_FAIRNESS_EN
    forced = (starve >= STARVE_MAX) && mdu_valid;
`else
    forced = 1'b0;
`endif
    g_wb   = !forced && wb_we;
    g_mdu  = forced || (!wb_we && mdu_valid);
    ea     = g_wb ? wb_rd   : (g_mdu ? mdu_rd   : 5'd0);
    ed     = g_wb ? wb_data : (g_mdu ? mdu_data : '0);
    exp_we = (g_wb || g_mdu) && (ea != 0);
    ir     = !mp[iss_rd];
    chk("rf_we",     rf_we,     exp_we);
    chk("rf_addr",   rf_addr,   ea);
    chk("rf_data",   rf_data,   ed);
    chk("mdu_ready", mdu_ready, g_mdu);
    chk("wb_stall",  wb_stall,  forced);
    chk("iss_ready", iss_ready, ir);
    chk("hz_rs1",    hz_rs1,    mp[chk_rs1] && chk_rs1 != 0);
    chk("hz_rs2",    hz_rs2,    mp[chk_rs2] && chk_rs2 != 0);
    chk("hz_rd",     hz_rd,     mp[chk_rd]  && chk_rd  != 0);
    if (wb_stall === 1'b1) stall_seen++;
    @(posedge clk);
    if (g_mdu) mp[mdu_rd] = 1'b0;
    if (iss_valid && ir && iss_rd != 0) mp[iss_rd] = 1'b1;
    if (g_mdu)          starve = 0;
    else if (mdu_valid) starve++;
    held_mdu = mdu_valid && !g_mdu;
    held_wb  = forced && wb_we;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    stall_seen = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pend_cnt",  pend_cnt,  0);
    chk("rst_iss_ready", iss_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // Issue to x5, then check hazard and refused re-issue.
    iss_valid = 1; iss_rd = 5;
    tick();
    chk("pend_cnt_after_issue", pend_cnt, 1);
    chk_rs1 = 5;
    tick();
    iss_valid = 0;

    // Pipeline wins over MDU, then MDU retires x5.
    wb_we = 1; wb_rd = 3; wb_data = 32'hAAAA_0001;
    mdu_valid = 1; mdu_rd = 5; mdu_data = 32'h1234;
    tick();
    wb_we = 0;
    tick();
    mdu_valid = 0;
    chk("pend_cnt_after_retire", pend_cnt, 0);

    // Same-edge retire and issue of x7: the issue keeps the bit set.
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h77;
    iss_valid = 1; iss_rd = 7;
    tick();
    mdu_valid = 0; iss_valid = 0; chk_rd = 7;
    tick();
    chk("hz_rd_x7_kept", hz_rd, 1);
    chk_rd = 0; chk_rs1 = 0;

    // x0 issue and x0 MDU result.
    iss_valid = 1; iss_rd = 0;
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'hDEAD;
    tick();
    iss_valid = 0; mdu_valid = 0;
    tick();

    // Pipeline and MDU both held busy for ten cycles.
    stall_seen = 0;
    wb_we = 1; wb_rd = 9; wb_data = 32'h99;
    mdu_valid = 1; mdu_rd = 12; mdu_data = 32'hC;
    repeat (10) tick();
`ifdef REGFILE_ARB_FAIRNESS_EN
    chk("stalls_in_10", stall_seen, 2);
`else
    chk("stalls_in_10", stall_seen, 0);
`endif
    idle_inputs();
    tick();

    // Set x1..x3 pending, then assert reset mid-cycle.
    for (int r = 1; r <= 3; r++) begin
      iss_valid = 1; iss_rd = 5'(r);
      tick();
    end
    iss_valid = 0;
    chk_rs1 = 1; chk_rs2 = 2; chk_rd = 3;
    wb_we = 1; wb_rd = 4; wb_data = 32'h4444;
    mdu_valid = 1; mdu_rd = 2; mdu_data = 32'h2222;
    #1;
    chk("pre_rst_hz_rs2", hz_rs2, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_hz_rs1",   hz_rs1,    0);
    chk("mid_rst_hz_rs2",   hz_rs2,    0);
    chk("mid_rst_hz_rd",    hz_rd,     0);
    chk("mid_rst_pend_cnt", pend_cnt,  0);
    chk("mid_rst_rf_we",    rf_we,     0);
    chk("mid_rst_mdu_rdy",  mdu_ready, 0);
    chk("mid_rst_wb_stall", wb_stall,  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wb_we = 0;
    // In-flight MDU result lands after reset and leaves nothing pending.
    tick();
    mdu_valid = 0;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if (!held_wb) begin
        wb_we   = ($urandom_range(0, 99) < 50);
        wb_rd   = 5'($urandom_range(0, 31));
        wb_data = $urandom;
      end
      if (!held_mdu) begin
        mdu_valid = ($urandom_range(0, 99) < 45);
        mdu_rd    = 5'($urandom_range(0, 31));
        mdu_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 50);
      iss_rd    = 5'($urandom_range(0, 31));
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = 5'($urandom_range(0, 31));
      chk_rd    = 5'($urandom_range(0, 31));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
